frame_guard: RTL and testbench

Multi-channel framing sanitiser: accepts an interleaved valid/sop/eop/data beat stream tagged with a channel number, tracks framing per channel, and emits a registered stream guaranteed to be well-formed per channel. Protocol violations (orphan beats, nested SOP, over-length frames) are repaired by dropping or truncating, reported with a one-cycle error pulse, and counted. It sits between an untrusted frame source and downstream consumers that rely on clean framing.

---
 rtl/frame_guard_pkg.sv | 25 ++
 rtl/frame_guard_ch.sv | 79 +++++++
 rtl/frame_guard.sv | 79 +++++++
 tb/tb_frame_guard.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/frame_guard_pkg.sv
// frame_guard_pkg: shared types for the frame_guard per-channel framing sanitiser.
package frame_guard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INFRAME = 2'd1,
    DISCARD = 2'd2
  } chState_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    ORPHAN  = 2'd1,
    NESTED  = 2'd2,
    OVERLEN = 2'd3
  } errCode_t;

  typedef struct packed {
    logic     pass;
    logic     sop;
    logic     eop;
    logic     err;
    errCode_t code;
  } beatAct_t;

endpackage

// File: rtl/frame_guard_ch.sv
// frame_guard_ch: one channel's framing state, optional length counter and beat decision.
//   i_clk, i_arst   clock, asynchronous active-high reset
//   i_en            beat on this channel this cycle (commits the state update)
//   i_sop, i_eop    input beat qualifiers
//   o_act           decision for a beat on this channel (valid regardless of i_en)
//   FRAME_GUARD_MAXLEN_EN adds the length counter and OVERLEN truncation.
module frame_guard_ch
  import frame_guard_pkg::*;
`ifdef FRAME_GUARD_MAXLEN_EN
  #(parameter int MAX_LEN = 64)
`endif
  (
  input  logic     i_clk,
  input  logic     i_arst,
  input  logic     i_en,
  input  logic     i_sop,
  input  logic     i_eop,
  output beatAct_t o_act
);

  chState_t state, stateNext;

  always_ff @(posedge i_clk or posedge i_arst)
    if (i_arst) state <= IDLE;
    else if (i_en) state <= stateNext;

`ifdef FRAME_GUARD_MAXLEN_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic [LEN_W-1:0] len, lenNext;

  always_ff @(posedge i_clk or posedge i_arst)
    if (i_arst) len <= '0;
    else if (i_en) len <= lenNext;
`endif

  always_comb begin
    o_act = '0;
    stateNext = state;
`ifdef FRAME_GUARD_MAXLEN_EN
    lenNext = len;
`endif
    if (state == INFRAME) begin
      if (i_sop) begin
        // A new SOP inside a frame closes the old frame on this very beat.
        o_act = '{pass: 1'b1, sop: 1'b0, eop: 1'b1, err: 1'b1, code: NESTED};
        stateNext = i_eop ? IDLE : DISCARD;
      end else begin
        o_act.pass = 1'b1;
        o_act.eop = i_eop;
        stateNext = i_eop ? IDLE : INFRAME;
`ifdef FRAME_GUARD_MAXLEN_EN
        lenNext = len + 1'b1;
        // Only a non-eop beat reaching the limit is truncated; an eop there is legal.
        if (!i_eop && lenNext == LEN_W'(MAX_LEN)) begin
          o_act.eop = 1'b1;
          o_act.err = 1'b1;
          o_act.code = OVERLEN;
          stateNext = DISCARD;
        end
`endif
      end
    end else if (i_sop) begin
      // DISCARD with sop restarts exactly like IDLE.
      o_act.pass = 1'b1;
      o_act.sop = 1'b1;
      o_act.eop = i_eop;
      stateNext = i_eop ? IDLE : INFRAME;
`ifdef FRAME_GUARD_MAXLEN_EN
      lenNext = LEN_W'(1);
`endif
    end else if (state == DISCARD) begin
      stateNext = i_eop ? IDLE : DISCARD;
    end else begin
      o_act.err = 1'b1;
      o_act.code = ORPHAN;
    end
  end

endmodule

// File: rtl/frame_guard.sv
// frame_guard: multi-channel framing sanitiser with registered, well-formed output.
//   i_clk, i_arst                  clock, asynchronous active-high reset
//   i_valid/i_sop/i_eop/i_ch/i_data  untrusted interleaved input beat
//   o_valid/o_sop/o_eop/o_ch/o_data  sanitised beat, one cycle later
//   o_err, o_errCode, o_errCount   error pulse, code (1 orphan, 2 nested, 3 overlen), saturating total
//   FRAME_GUARD_MAXLEN_EN enables MAX_LEN truncation.
module frame_guard
  import frame_guard_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_valid,
  input  logic                      i_sop,
  input  logic                      i_eop,
  input  logic [$clog2(NUM_CH)-1:0] i_ch,
  input  logic [DATA_W-1:0]         i_data,
  output logic                      o_valid,
  output logic                      o_sop,
  output logic                      o_eop,
  output logic [$clog2(NUM_CH)-1:0] o_ch,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_err,
  output logic [1:0]                o_errCode,
  output logic [CNT_W-1:0]          o_errCount
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || MAX_LEN < 2) begin : gBadParam
    $error("frame_guard: NUM_CH and MAX_LEN must be at least 2");
  end

  beatAct_t acts [NUM_CH];
  beatAct_t sel;

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
`ifdef FRAME_GUARD_MAXLEN_EN
    frame_guard_ch #(.MAX_LEN(MAX_LEN)) uCh (
`else
    frame_guard_ch uCh (
`endif
      .i_clk (i_clk),
      .i_arst(i_arst),
      .i_en  (i_valid && i_ch == CH_W'(c)),
      .i_sop (i_sop),
      .i_eop (i_eop),
      .o_act (acts[c])
    );
  end

  assign sel = acts[i_ch];

  always_ff @(posedge i_clk or posedge i_arst)
    if (i_arst) begin
      o_valid <= 1'b0;
      o_sop <= 1'b0;
      o_eop <= 1'b0;
      o_ch <= '0;
      o_data <= '0;
      o_err <= 1'b0;
      o_errCode <= 2'd0;
      o_errCount <= '0;
    end else begin
      o_valid <= i_valid && sel.pass;
      o_sop <= i_valid && sel.pass && sel.sop;
      o_eop <= i_valid && sel.pass && sel.eop;
      o_ch <= i_ch;
      o_data <= i_data;
      o_err <= i_valid && sel.err;
      o_errCode <= (i_valid && sel.err) ? sel.code : NONE;
      if (i_valid && sel.err && !(&o_errCount)) o_errCount <= o_errCount + 1'b1;
    end

endmodule

// File: tb/tb_frame_guard.sv
// tb_frame_guard: scoreboard bench for frame_guard with hand-computed directed vectors.
module tb_frame_guard;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       iValid = 1'b0, iSop = 1'b0, iEop = 1'b0;
  logic [1:0] iCh = '0;
  logic [7:0] iData = '0;
  logic       oValid, oSop, oEop, oErr;
  logic [1:0] oCh, oErrCode, oErrCount;
  logic [7:0] oData;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v, s, e;
    logic [1:0] ch;
    logic [7:0] d;
    logic [1:0] code;
    logic [1:0] cnt;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];

  frame_guard #(.DATA_W(8), .NUM_CH(4), .MAX_LEN(4), .CNT_W(2)) dut (
    .i_clk(clk), .i_arst(arst), .i_valid(iValid), .i_sop(iSop), .i_eop(iEop),
    .i_ch(iCh), .i_data(iData), .o_valid(oValid), .o_sop(oSop), .o_eop(oEop),
    .o_ch(oCh), .o_data(oData), .o_err(oErr), .o_errCode(oErrCode), .o_errCount(oErrCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (oValid || oErr) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got v=%0b s=%0b e=%0b ch=%0d d=%02h err=%0b code=%0d, want no output",
                 oValid, oSop, oEop, oCh, oData, oErr, oErrCode);
      end else begin
        exp_t  x;
        string nm;
        x = expQ.pop_front();
        nm = nameQ.pop_front();
        if (!(oValid == x.v && oSop == x.s && oEop == x.e && oErr == (x.code != 2'd0) &&
              oErrCode == x.code && oErrCount == x.cnt && (!x.v || (oCh == x.ch && oData == x.d)))) begin
          errors++;
          $display("FAIL %s: got v=%0b s=%0b e=%0b ch=%0d d=%02h err=%0b code=%0d cnt=%0d, want v=%0b s=%0b e=%0b ch=%0d d=%02h code=%0d cnt=%0d",
                   nm, oValid, oSop, oEop, oCh, oData, oErr, oErrCode, oErrCount,
                   x.v, x.s, x.e, x.ch, x.d, x.code, x.cnt);
        end
      end
    end
  end

  task automatic send(input string nm, input logic [1:0] ch, input logic s, input logic e,
                      input logic [7:0] d, input logic ev, input logic es, input logic ee,
                      input logic [1:0] code, input logic [1:0] cnt);
    @(negedge clk);
    iValid = 1'b1; iSop = s; iEop = e; iCh = ch; iData = d;
    if (ev || code != 2'd0) begin
      expQ.push_back('{v: ev, s: es, e: ee, ch: ch, d: d, code: code, cnt: cnt});
      nameQ.push_back(nm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iValid = 1'b0; iSop = 1'b0; iEop = 1'b0;
    end
  endtask

  task automatic checkZero(input string nm);
    checks++;
    if ({oValid, oSop, oEop, oCh, oData, oErr, oErrCode, oErrCount} != '0) begin
      errors++;
      $display("FAIL %s: got v=%0b s=%0b e=%0b ch=%0d d=%02h err=%0b code=%0d cnt=%0d, want all zero",
               nm, oValid, oSop, oEop, oCh, oData, oErr, oErrCode, oErrCount);
    end
  endtask

  task automatic doRst();
    @(negedge clk);
    iValid = 1'b0; iSop = 1'b0; iEop = 1'b0;
    arst = 1'b1;
    #1 checkZero("reset");
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    doRst();

    send("clean0_sop", 2'd0, 1, 0, 8'h01, 1, 1, 0, 2'd0, 2'd0);
    send("clean1_se",  2'd1, 1, 1, 8'hA1, 1, 1, 1, 2'd0, 2'd0);
    send("clean0_m1",  2'd0, 0, 0, 8'h02, 1, 0, 0, 2'd0, 2'd0);
    send("clean0_m2",  2'd0, 0, 0, 8'h03, 1, 0, 0, 2'd0, 2'd0);
    send("clean1_se2", 2'd1, 1, 1, 8'hA2, 1, 1, 1, 2'd0, 2'd0);
    send("clean0_eop", 2'd0, 0, 1, 8'h04, 1, 0, 1, 2'd0, 2'd0);
    idle(2);

    send("orphan", 2'd2, 0, 0, 8'h5A, 0, 0, 0, 2'd1, 2'd1);
    idle(1);

    send("nest_sop",  2'd1, 1, 0, 8'h10, 1, 1, 0, 2'd0, 2'd1);
    send("nest_mid",  2'd1, 0, 0, 8'h20, 1, 0, 0, 2'd0, 2'd1);
    send("nest_sop2", 2'd1, 1, 0, 8'h11, 1, 0, 1, 2'd2, 2'd2);
    send("nest_drop", 2'd1, 0, 0, 8'h12, 0, 0, 0, 2'd0, 2'd2);
    send("nest_deop", 2'd1, 0, 1, 8'h13, 0, 0, 0, 2'd0, 2'd2);
    send("nest_next", 2'd1, 1, 1, 8'h14, 1, 1, 1, 2'd0, 2'd2);
    idle(2);

    doRst();
`ifdef FRAME_GUARD_MAXLEN_EN
    send("ovl_sop",  2'd3, 1, 0, 8'h30, 1, 1, 0, 2'd0, 2'd0);
    send("ovl_m1",   2'd3, 0, 0, 8'h31, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_m2",   2'd3, 0, 0, 8'h32, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_trunc",2'd3, 0, 0, 8'h33, 1, 0, 1, 2'd3, 2'd1);
    send("ovl_other",2'd0, 1, 1, 8'hC0, 1, 1, 1, 2'd0, 2'd1);
    send("ovl_d4",   2'd3, 0, 0, 8'h34, 0, 0, 0, 2'd0, 2'd1);
    send("ovl_d5",   2'd3, 0, 0, 8'h35, 0, 0, 0, 2'd0, 2'd1);
    send("ovl_deop", 2'd3, 0, 1, 8'h36, 0, 0, 0, 2'd0, 2'd1);
    send("ovl_next", 2'd3, 1, 1, 8'h37, 1, 1, 1, 2'd0, 2'd1);
`else
    send("ovl_sop",  2'd3, 1, 0, 8'h30, 1, 1, 0, 2'd0, 2'd0);
    send("ovl_m1",   2'd3, 0, 0, 8'h31, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_m2",   2'd3, 0, 0, 8'h32, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_m3",   2'd3, 0, 0, 8'h33, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_other",2'd0, 1, 1, 8'hC0, 1, 1, 1, 2'd0, 2'd0);
    send("ovl_m4",   2'd3, 0, 0, 8'h34, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_m5",   2'd3, 0, 0, 8'h35, 1, 0, 0, 2'd0, 2'd0);
    send("ovl_eop",  2'd3, 0, 1, 8'h36, 1, 0, 1, 2'd0, 2'd0);
    send("ovl_next", 2'd3, 1, 1, 8'h37, 1, 1, 1, 2'd0, 2'd0);
`endif
    idle(2);

    doRst();
    send("sat1", 2'd0, 0, 0, 8'h00, 0, 0, 0, 2'd1, 2'd1);
    send("sat2", 2'd1, 0, 1, 8'h01, 0, 0, 0, 2'd1, 2'd2);
    send("sat3", 2'd2, 0, 0, 8'h02, 0, 0, 0, 2'd1, 2'd3);
    send("sat4", 2'd3, 0, 0, 8'h03, 0, 0, 0, 2'd1, 2'd3);
    send("sat5", 2'd0, 0, 1, 8'h04, 0, 0, 0, 2'd1, 2'd3);
    idle(2);

    doRst();
    send("rst_sop", 2'd0, 1, 0, 8'h40, 1, 1, 0, 2'd0, 2'd0);
    send("rst_mid", 2'd0, 0, 0, 8'h41, 1, 0, 0, 2'd0, 2'd0);
    @(negedge clk);
    iValid = 1'b0; iSop = 1'b0; iEop = 1'b0;
    #2 arst = 1'b1;
    #1 checkZero("async_reset");
    @(negedge clk);
    arst = 1'b0;
    send("rst_orphan", 2'd0, 0, 0, 8'h42, 0, 0, 0, 2'd1, 2'd1);
    idle(3);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: got %0d expected beats never seen, want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
